// File: rtl/median_sched.sv
// median_sched: shares one median_calc between NCH channels, one full batch at a time.
// Channels are granted round-robin; each batch is streamed as spaced data_rdy pulses
// and the resulting median is returned tagged with the owning channel.
// Optional feature macro: MEDIAN_SCHED_TIMEOUT_EN bounds WAIT_RES to TIMEOUT cycles.

module median_sched #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned POPSIZE    = 100,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP        = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            ch_valid_i,
    input  logic [NCH*DATA_WIDTH-1:0] ch_data_i,
    output logic [NCH-1:0]            ch_ready_o,
    output logic [DATA_WIDTH-1:0]     mc_data_in_o,
    output logic                      mc_data_rdy_o,
    input  logic [DATA_WIDTH-1:0]     mc_median_i,
    input  logic                      mc_data_vld_i,
    output logic                      res_valid_o,
    output logic [DATA_WIDTH-1:0]     res_median_o,
    output logic [$clog2(NCH)-1:0]    res_ch_o,
    output logic                      res_err_o,
    output logic                      busy_o
);

    localparam int unsigned CHW  = $clog2(NCH);
    localparam int unsigned IDXW = CHW + 1;
    localparam int unsigned CNTW = $clog2(POPSIZE + 1);
    localparam int unsigned GAPW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_GAP,
        S_WAIT_RES,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [CHW-1:0]          rr_ptr_q;
    logic [CHW-1:0]          grant_ch_q;
    logic [CNTW-1:0]         sample_cnt_q;
    logic [GAPW-1:0]         gap_cnt_q;
    logic [NCH-1:0]          ch_ready_q;
    logic [DATA_WIDTH-1:0]   mc_data_in_q;
    logic                    mc_data_rdy_q;
    logic                    res_valid_q;
    logic [DATA_WIDTH-1:0]   res_median_q;
    logic [CHW-1:0]          res_ch_q;
    logic                    busy_q;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0]          to_cnt_q;
    logic                    res_err_q;
`endif

    logic                    arb_hit_d;
    logic [CHW-1:0]          arb_ch_d;
    logic [IDXW-1:0]         arb_idx;
    logic [DATA_WIDTH-1:0]   sel_data_d;
    logic                    accept_d;
    logic [NCH-1:0]          grant_onehot_d;

    // Round-robin pick: first valid channel scanning upward from rr_ptr with wrap.
    always_comb begin
        arb_hit_d = 1'b0;
        arb_ch_d  = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            arb_idx = IDXW'(rr_ptr_q) + IDXW'(k);
            if (arb_idx >= IDXW'(NCH)) begin
                arb_idx = arb_idx - IDXW'(NCH);
            end
            if (!arb_hit_d && ch_valid_i[CHW'(arb_idx)]) begin
                arb_hit_d = 1'b1;
                arb_ch_d  = CHW'(arb_idx);
            end
        end
    end

    // Sample of the granted channel, handshake detect and grant one-hot.
    always_comb begin
        sel_data_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_ch_q == CHW'(i)) begin
                sel_data_d = ch_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        accept_d       = |(ch_valid_i & ch_ready_q);
        grant_onehot_d = NCH'(1) << grant_ch_q;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_ch_q    <= '0;
            sample_cnt_q  <= '0;
            gap_cnt_q     <= '0;
            ch_ready_q    <= '0;
            mc_data_in_q  <= '0;
            mc_data_rdy_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_median_q  <= '0;
            res_ch_q      <= '0;
            busy_q        <= 1'b0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
            to_cnt_q      <= '0;
            res_err_q     <= 1'b0;
`endif
        end else begin
            mc_data_rdy_q <= 1'b0;
            res_valid_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_hit_d) begin
                        grant_ch_q <= arb_ch_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (accept_d) begin
                        ch_ready_q    <= '0;
                        mc_data_in_q  <= sel_data_d;
                        mc_data_rdy_q <= 1'b1;
                        sample_cnt_q  <= sample_cnt_q + CNTW'(1);
                        if (sample_cnt_q == CNTW'(POPSIZE - 1)) begin
                            state_q <= S_WAIT_RES;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end else if (GAP == 0) begin
                            state_q <= S_FEED;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end else if (ch_ready_q == '0) begin
                        // Ready is raised one cycle after entering FEED, giving GAP+2 spacing.
                        ch_ready_q <= grant_onehot_d;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAPW'(GAP - 1)) begin
                        state_q <= S_FEED;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAPW'(1);
                    end
                end
                S_WAIT_RES: begin
                    if (mc_data_vld_i) begin
                        res_median_q <= mc_median_i;
                        res_ch_q     <= grant_ch_q;
                        res_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
                        res_err_q    <= 1'b0;
`endif
                    end
`ifdef MEDIAN_SCHED_TIMEOUT_EN
                    else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
                        res_median_q <= '0;
                        res_ch_q     <= grant_ch_q;
                        res_valid_q  <= 1'b1;
                        res_err_q    <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
`endif
                end
                S_DONE: begin
                    rr_ptr_q     <= (grant_ch_q == CHW'(NCH - 1)) ? '0 : grant_ch_q + CHW'(1);
                    sample_cnt_q <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_ready_o    = ch_ready_q;
    assign mc_data_in_o  = mc_data_in_q;
    assign mc_data_rdy_o = mc_data_rdy_q;
    assign res_valid_o   = res_valid_q;
    assign res_median_o  = res_median_q;
    assign res_ch_o      = res_ch_q;
    assign busy_o        = busy_q;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
    assign res_err_o     = res_err_q;
`else
    assign res_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_median_sched.sv
// tb_median_sched: randomized scoreboard bench for median_sched with a behavioural
// median_calc stand-in and a batch-level round-robin reference model.

module tb_median_sched;

    localparam int unsigned NCH     = 4;
    localparam int unsigned POPSIZE = 5;
    localparam int unsigned DW      = 8;
    localparam int unsigned GAP     = 2;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        int ch;
        int med;
        bit err;
        bit to;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_ready;
    logic [DW-1:0]     mc_data_in;
    logic              mc_data_rdy;
    logic [DW-1:0]     mc_median = '0;
    logic              mc_data_vld = 1'b0;
    logic              res_valid;
    logic [DW-1:0]     res_median;
    logic [1:0]        res_ch;
    logic              res_err;
    logic              busy;

    median_sched #(
        .NCH       (NCH),
        .POPSIZE   (POPSIZE),
        .DATA_WIDTH(DW),
        .GAP       (GAP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_valid_i   (ch_valid),
        .ch_data_i    (ch_data),
        .ch_ready_o   (ch_ready),
        .mc_data_in_o (mc_data_in),
        .mc_data_rdy_o(mc_data_rdy),
        .mc_median_i  (mc_median),
        .mc_data_vld_i(mc_data_vld),
        .res_valid_o  (res_valid),
        .res_median_o (res_median),
        .res_ch_o     (res_ch),
        .res_err_o    (res_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Source queues (what the driver presents) and the model's copy of pending batches.
    logic [DW-1:0] src_q  [NCH][$];
    logic [DW-1:0] pend_q [NCH][$];
    logic [DW-1:0] exp_samp [$];
    res_t          exp_res  [$];
    int            mdl_rr = 0;

    int stall_tgt  = 0;
    bit stall_arm  = 1'b0;
    int stall_acc  = 0;
    int stall_left = 0;
    bit stall_seen = 1'b0;
    bit no_vld     = 1'b0;

    int            batch_idx      = 0;
    int            last_rdy       = 0;
    int            last_batch_cyc = 0;
    logic [DW-1:0] mc_buf [$];
    bit            vld_pend  = 1'b0;
    int            vld_delay = 0;
    logic [DW-1:0] vld_med   = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endfunction

    function automatic void fail(string name, logic [31:0] act);
        n_checks++;
        $display("FAIL %s: actual=%0d required=none", name, act);
    endfunction

    function automatic int median_of(logic [DW-1:0] s [$]);
        logic [DW-1:0] t [$];
        t = s;
        t.sort();
        return int'(t[POPSIZE/2]);
    endfunction

    function automatic void add_batch(int ch, logic [DW-1:0] s [$]);
        foreach (s[j]) begin
            src_q[ch].push_back(s[j]);
            pend_q[ch].push_back(s[j]);
        end
    endfunction

    function automatic void add_rand(int ch);
        logic [DW-1:0] s [$];
        for (int j = 0; j < POPSIZE; j++) s.push_back(DW'($urandom_range(0, 255)));
        add_batch(ch, s);
    endfunction

    // Reference: grant whole batches round-robin among channels with pending data.
    function automatic void predict();
        logic [DW-1:0] b [$];
        res_t r;
        int ch;
        for (int n = 0; n < 64; n++) begin
            ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (mdl_rr + k) % NCH;
                if (ch < 0 && pend_q[c].size() > 0) ch = c;
            end
            if (ch < 0) break;
            b.delete();
            for (int j = 0; j < POPSIZE; j++) begin
                b.push_back(pend_q[ch].pop_front());
                exp_samp.push_back(b[j]);
            end
            r.ch  = ch;
            r.err = no_vld;
            r.to  = no_vld;
            r.med = no_vld ? 0 : median_of(b);
            exp_res.push_back(r);
            mdl_rr = (ch + 1) % NCH;
        end
    endfunction

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((exp_res.size() > 0 || exp_samp.size() > 0 || busy) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 3000) fail(name, 32'(exp_res.size()));
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_ch_ready"},   32'(ch_ready),    0);
        chk({tag, "_mc_rdy"},     32'(mc_data_rdy), 0);
        chk({tag, "_mc_data_in"}, 32'(mc_data_in),  0);
        chk({tag, "_res_valid"},  32'(res_valid),   0);
        chk({tag, "_res_median"}, 32'(res_median),  0);
        chk({tag, "_res_ch"},     32'(res_ch),      0);
        chk({tag, "_res_err"},    32'(res_err),     0);
        chk({tag, "_busy"},       32'(busy),        0);
    endtask

    initial forever @(posedge clk) cyc++;

    // Source driver: retire accepted samples after each edge and present the next ones.
    initial begin
        logic [NCH-1:0] hs;
        forever begin
            @(posedge clk);
            hs = ch_valid & ch_ready;
            #1;
            if (stall_left > 0) stall_left--;
            for (int i = 0; i < NCH; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    if (stall_arm && i == stall_tgt) begin
                        stall_acc++;
                        if (stall_acc == 3) begin
                            stall_left = 20;
                            stall_arm  = 1'b0;
                            stall_seen = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < NCH; i++) begin
                ch_valid[i] = (src_q[i].size() > 0) && !(stall_left > 0 && i == stall_tgt);
                ch_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
        end
    end

    // Monitor and median_calc stand-in: checks the sample stream and results.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            mc_data_vld = 1'b0;
            if (rst) begin
                mc_buf.delete();
                vld_pend   = 1'b0;
                batch_idx  = 0;
                stall_seen = 1'b0;
            end else begin
                if (vld_pend) begin
                    vld_delay--;
                    if (vld_delay == 0) begin
                        mc_data_vld = 1'b1;
                        mc_median   = vld_med;
                        vld_pend    = 1'b0;
                    end
                end
                if (stall_left > 0 && stall_left < 20) begin
                    chk("stall_no_rdy", 32'(mc_data_rdy), 0);
                    chk("stall_busy", 32'(busy), 1);
                    chk("stall_no_other_grant", 32'(ch_ready & ~(NCH'(1) << stall_tgt)), 0);
                end
                if (mc_data_rdy) begin
                    if (exp_samp.size() == 0) fail("rdy_unexpected", 32'(mc_data_in));
                    else chk("mc_data_in", 32'(mc_data_in), 32'(exp_samp.pop_front()));
                    if (batch_idx > 0) begin
                        if (stall_seen) chk("rdy_spacing_min", 32'((cyc - last_rdy) >= int'(GAP + 2)), 1);
                        else chk("rdy_spacing", 32'(cyc - last_rdy), 32'(GAP + 2));
                    end
                    last_rdy = cyc;
                    mc_buf.push_back(mc_data_in);
                    batch_idx++;
                    if (batch_idx == POPSIZE) begin
                        batch_idx      = 0;
                        stall_seen     = 1'b0;
                        last_batch_cyc = cyc;
                        if (!no_vld) begin
                            vld_med   = DW'(median_of(mc_buf));
                            vld_delay = $urandom_range(1, 6);
                            vld_pend  = 1'b1;
                        end
                        mc_buf.delete();
                    end
                end
                if (res_valid) begin
                    if (exp_res.size() == 0) fail("res_unexpected", 32'(res_ch));
                    else begin
                        r = exp_res.pop_front();
                        chk("res_ch", 32'(res_ch), 32'(r.ch));
                        chk("res_median", 32'(res_median), 32'(r.med));
                        chk("res_err", 32'(res_err), 32'(r.err));
                        if (r.to) chk("timeout_latency", 32'(cyc - last_batch_cyc), 32'(TIMEOUT));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Main sequence of scenarios.
    initial begin
        logic [DW-1:0] s [$];
        int n;
        int nb;
        bit any;

        repeat (3) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        // Single channel, fixed batch.
        s = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
        add_batch(0, s);
        predict();
        wait_drain("single_drain");

        // Round-robin with all channels holding two batches.
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NCH; c++) add_rand(c);
        predict();
        wait_drain("rr_drain");

        // Wrap and skip: move rr_ptr to 3, then only ch1 valid, then check rr_ptr=2.
        add_rand(2); predict(); wait_drain("wrap_a_drain");
        add_rand(1); predict(); wait_drain("wrap_b_drain");
        add_rand(0); add_rand(2); add_rand(3); predict(); wait_drain("wrap_c_drain");

        // Stall of the owning channel after its third sample.
        stall_tgt = 2;
        stall_acc = 0;
        stall_arm = 1'b1;
        add_rand(2); add_rand(0); add_rand(3);
        predict();
        wait_drain("stall_drain");
        chk("stall_occurred", 32'(stall_arm), 0);

        // Reset after two samples of a batch.
        add_rand(1);
        predict();
        n = 0;
        while (batch_idx < 2 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 1000) fail("reset_wait", 32'(batch_idx));
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            src_q[i].delete();
            pend_q[i].delete();
        end
        exp_samp.delete();
        exp_res.delete();
        mdl_rr = 0;
        @(negedge clk); #1;
        chk_zero_outputs("midreset");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        add_rand(2); add_rand(0);
        predict();
        wait_drain("post_reset_drain");

        // Randomized load patterns.
        for (int p = 0; p < 6; p++) begin
            any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                nb = $urandom_range(0, 2);
                for (int k = 0; k < nb; k++) add_rand(c);
                if (nb > 0) any = 1'b1;
            end
            if (!any) add_rand($urandom_range(0, NCH - 1));
            predict();
            wait_drain("random_drain");
        end

`ifdef MEDIAN_SCHED_TIMEOUT_EN
        // median_calc never answers: expect a timeout result.
        no_vld = 1'b1;
        add_rand(1);
        predict();
        wait_drain("timeout_drain");
        no_vld = 1'b0;
        add_rand(3);
        predict();
        wait_drain("after_timeout_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/median_sched.md
Name: median_sched

Overview:
- Shares one median_calc instance between NCH requesting channels.
- Grants one channel at a time, round-robin, for a full batch of POPSIZE samples.
- Feeds that batch to median_calc as spaced single-cycle data_rdy pulses, waits for data_vld, then returns the median tagged with the channel id.
- Sits between the sample sources and median_calc; drives every median_calc input except clk/rst.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- POPSIZE, 100, samples per batch; must equal the median_calc POPSIZE.
- DATA_WIDTH, 8, sample and median width.
- GAP, 2, idle cycles between consecutive mc_data_rdy pulses (0..15).
- TIMEOUT, 1024, cycles allowed in WAIT_RES (used only with MEDIAN_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset; also drives median_calc rst.
- ch_valid  in  NCH  channel i has a sample on ch_data slice i.
- ch_data  in  NCH*DATA_WIDTH  packed samples; channel i occupies [i*DW +: DW].
- ch_ready  out  NCH  one-hot; sample from channel i is accepted when ch_valid[i] && ch_ready[i].
- mc_data_in  out  DATA_WIDTH  to median_calc data_in.
- mc_data_rdy  out  1  to median_calc data_rdy; single-cycle pulse per sample.
- mc_median  in  DATA_WIDTH  from median_calc median.
- mc_data_vld  in  1  from median_calc data_vld.
- res_valid  out  1  one-cycle pulse; result present.
- res_median  out  DATA_WIDTH  median of the batch; held until the next res_valid.
- res_ch  out  $clog2(NCH)  channel that owned the batch; held with res_median.
- res_err  out  1  timeout flag, qualified by res_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: ch_ready=0, mc_data_rdy=0, mc_data_in=0, res_valid=0, res_median=0, res_ch=0, res_err=0, busy=0. FSM=IDLE, rr_ptr=0, sample_cnt=0, gap_cnt=0.
- FSM states: IDLE, FEED, GAP, WAIT_RES, DONE.
- IDLE: if any ch_valid, grant the first set bit scanning from rr_ptr upward with wrap-around, register grant_ch, then go to FEED next cycle. Otherwise stay in IDLE.
- FEED: ch_ready[grant_ch]=1 (registered, other bits 0). On ch_valid[grant_ch]:
  - sample accepted.
  - Next cycle: mc_data_in=sample, mc_data_rdy=1 for exactly one cycle.
  - sample_cnt++; ch_ready drops.
  - If sample_cnt reaches POPSIZE, go to WAIT_RES; else go to GAP (or straight back to FEED if GAP=0).
- Other channels' ch_valid is ignored while a batch is owned; a granted channel that stalls simply holds the FSM in FEED.
- GAP: count GAP cycles with ch_ready=0, then return to FEED. Minimum spacing between mc_data_rdy rising edges is GAP+2 cycles.
- WAIT_RES: all ch_ready=0. On mc_data_vld: capture mc_median into res_median and grant_ch into res_ch, then go to DONE. mc_data_vld seen in any other state is ignored.
- DONE: res_valid=1 for one cycle, res_err=0. Set rr_ptr=(grant_ch+1) mod NCH, clear sample_cnt, return to IDLE.
- Result latency: res_valid is asserted 1 cycle after the mc_data_vld capture edge.
- Fairness: with all channels continuously valid, grants go 0,1,..,NCH-1,0. No channel waits more than NCH-1 batches.
- Reset mid-batch: the partial batch is discarded; no res_valid is produced. Grant restarts from channel 0.
- sample_cnt width is $clog2(POPSIZE+1); no wrap occurs inside a batch.

Optional Feature:
- Macro: MEDIAN_SCHED_TIMEOUT_EN.
- Defined: WAIT_RES runs a counter. If TIMEOUT cycles elapse without mc_data_vld, go to DONE with res_valid=1, res_err=1, res_median=0, res_ch=grant_ch. rr_ptr advances as usual. An mc_data_vld in the same cycle as expiry wins, with res_err=0.
- Not defined: no counter; WAIT_RES waits indefinitely; res_err is tied 0.

Test Plan:
- Single channel: NCH=4, POPSIZE=5, GAP=2, ch0 sends 9,3,7,1,5 with ch_valid held high. Expect 5 mc_data_rdy pulses carrying 9,3,7,1,5, rising edges exactly 4 cycles apart. Model returns 5 → res_valid pulse with res_median=5, res_ch=0.
- Round-robin: ch0..ch3 all continuously valid, 8 batches. Expect res_ch sequence 0,1,2,3,0,1,2,3, and no interleaved samples across channels on mc_data_in.
- Wrap and skip: rr_ptr=3, only ch1 valid. Expect grant to ch1, then rr_ptr=2.
- Stall: ch2 drops ch_valid for 20 cycles after its 3rd sample. Expect no mc_data_rdy during the stall, busy=1, other valid channels not granted, and the batch completing with 5 samples.
- Reset mid-batch: assert rst after 2 of 5 samples. Expect all outputs 0 the next cycle and no res_valid. The following batch needs a full 5 samples.
- Timeout (macro defined, TIMEOUT=16): model never asserts data_vld. Expect res_valid with res_err=1, res_median=0 exactly 16 cycles after entering WAIT_RES, then IDLE.
